// File: rtl/uart_tx_sched_if.sv
// Scheduler-side bundle: FIFO read port and transmitter launch port.
// master = the scheduler, slave = the FIFO/transmitter environment.
interface uart_tx_sched_if #(
  parameter int W = 8
);
  logic         enable;
  logic         fifo_empty;
  logic [W-1:0] fifo_rdata;
  logic         fifo_rinc;
  logic         tx_busy;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic [15:0]  sent_cnt;
  logic         retry;

  modport master (
    input  enable, fifo_empty, fifo_rdata, tx_busy,
    output fifo_rinc, tx_data, tx_valid, sent_cnt, retry
  );

  modport slave (
    output enable, fifo_empty, fifo_rdata, tx_busy,
    input  fifo_rinc, tx_data, tx_valid, sent_cnt, retry
  );
endinterface

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: pops one byte from an FWFT FIFO, launches it with a
// one-cycle strobe, re-launches when busy never rises, waits for completion,
// then inserts an idle gap before the next frame.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for enable, non-empty FIFO and idle transmitter
// S_LAUNCH | one cycle; strobes are registered on the exit edge
// S_WAIT_HI| waiting for tx_busy to rise, ack timer running
// S_WAIT_LO| frame in flight, waiting for tx_busy to fall
// S_GAP    | inter-frame idle time
module uart_tx_sched #(
  parameter int W      = 8,
  parameter int GAP    = 2,
  parameter int ACK_TO = 8
) (
  input  logic clk,
  input  logic rst,
  uart_tx_sched_if.master bus
);

  localparam int TW = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  // Timers load N-1 and expire on the cycle they are seen at zero.
  localparam logic [TW-1:0] TO_LOAD  = TW'(ACK_TO - 1);
  localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_HI,
    S_WAIT_LO,
    S_GAP
  } state_t;

  state_t        state;
  logic [TW-1:0] to_cnt;
  logic [GW-1:0] gap_cnt;
  logic          relaunch;

  // Single sequential FSM; every output is a register, strobes default low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      to_cnt        <= '0;
      gap_cnt       <= '0;
      relaunch      <= 1'b0;
      bus.tx_data   <= '0;
      bus.tx_valid  <= 1'b0;
      bus.fifo_rinc <= 1'b0;
      bus.sent_cnt  <= '0;
      bus.retry     <= 1'b0;
    end else begin
      bus.tx_valid  <= 1'b0;
      bus.fifo_rinc <= 1'b0;
      bus.retry     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.enable && !bus.fifo_empty && !bus.tx_busy) begin
            bus.tx_data <= bus.fifo_rdata;
            relaunch    <= 1'b0;
            state       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          // Pop the FIFO only on the first launch; a re-launch reuses tx_data.
          bus.tx_valid  <= 1'b1;
          bus.fifo_rinc <= !relaunch;
          bus.retry     <= relaunch;
          to_cnt        <= TO_LOAD;
          state         <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          // Busy rise takes priority over a timeout expiring on the same edge.
          if (bus.tx_busy) begin
            state <= S_WAIT_LO;
          end else if (to_cnt == '0) begin
            relaunch <= 1'b1;
            state    <= S_LAUNCH;
          end else begin
            to_cnt <= to_cnt - TW'(1);
          end
        end
        S_WAIT_LO: begin
          if (!bus.tx_busy) begin
            bus.sent_cnt <= bus.sent_cnt + 16'd1;
            if (GAP > 0) begin
              gap_cnt <= GAP_LOAD;
              state   <= S_GAP;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: FWFT FIFO model, transmitter model, and a launch
// scoreboard fed by the bytes pushed into the FIFO.
module tb_uart_tx_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.W(8)) u_if ();

  uart_tx_sched #(.W(8), .GAP(2), .ACK_TO(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.master)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // FIFO model
  logic [7:0] fifo_mem [16];
  int fifo_rd = 0;
  int fifo_wr = 0;
  assign u_if.fifo_empty = (fifo_rd == fifo_wr);
  assign u_if.fifo_rdata = fifo_mem[fifo_rd[3:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (u_if.fifo_rinc === 1'b1) fifo_rd <= fifo_rd + 1;
  end

  // Scoreboard state
  logic [7:0] exp_q [$];
  int launch_q [$];
  int fall_q [$];
  int n_valid = 0;
  int n_rinc  = 0;
  int n_retry = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] mon_exp;
  int tx_ignore = 0;

  task automatic push_byte(input logic [7:0] b);
    fifo_mem[fifo_wr[3:0]] = b;
    fifo_wr = fifo_wr + 1;
    exp_q.push_back(b);
  endtask

  task automatic wait_sent(input logic [15:0] target);
    for (int i = 0; i < 400 && u_if.sent_cnt !== target; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 100 && u_if.tx_busy !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Launch monitor: first launches pop the scoreboard, re-launches must repeat the byte.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (u_if.tx_valid === 1'b1) begin
        n_valid++;
        launch_q.push_back(cyc);
        n_total++;
        if (u_if.fifo_rinc === 1'b1) begin
          n_rinc++;
          if (exp_q.size() == 0) begin
            $display("FAIL launch_unexpected: tx_data=%h, required no launch", u_if.tx_data);
          end else begin
            mon_exp = exp_q.pop_front();
            if (u_if.tx_data !== mon_exp)
              $display("FAIL launch_data: tx_data=%h, required %h", u_if.tx_data, mon_exp);
            else n_pass++;
          end
          last_data = u_if.tx_data;
        end else begin
          if (u_if.tx_data !== last_data)
            $display("FAIL relaunch_data: tx_data=%h, required %h", u_if.tx_data, last_data);
          else n_pass++;
        end
        n_total++;
        if (u_if.retry !== ~u_if.fifo_rinc)
          $display("FAIL retry_vs_rinc: retry=%b fifo_rinc=%b, required opposite", u_if.retry, u_if.fifo_rinc);
        else n_pass++;
        if (u_if.retry === 1'b1) n_retry++;
      end else if (u_if.fifo_rinc !== 1'b0 || u_if.retry !== 1'b0) begin
        n_total++;
        $display("FAIL stray_strobe: fifo_rinc=%b retry=%b without tx_valid, required 0", u_if.fifo_rinc, u_if.retry);
      end
    end
  end

  // Transmitter model: busy rises 2 cycles after valid and holds for 10 cycles.
  initial begin
    u_if.tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (u_if.tx_valid === 1'b1) begin
        if (tx_ignore > 0) begin
          tx_ignore--;
        end else begin
          repeat (2) @(posedge clk);
          #1 u_if.tx_busy = 1'b1;
          repeat (10) @(posedge clk);
          #1 u_if.tx_busy = 1'b0;
          fall_q.push_back(cyc + 1);
        end
      end
    end
  end

  task automatic test_reset();
    int v0;
    u_if.enable = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_total++;
    if (u_if.tx_valid !== 1'b0 || u_if.fifo_rinc !== 1'b0 || u_if.retry !== 1'b0)
      $display("FAIL reset_strobes: valid=%b rinc=%b retry=%b, required 0", u_if.tx_valid, u_if.fifo_rinc, u_if.retry);
    else n_pass++;
    n_total++;
    if (u_if.tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h, required 00", u_if.tx_data);
    else n_pass++;
    n_total++;
    if (u_if.sent_cnt !== 16'h0000) $display("FAIL reset_sent_cnt: got %h, required 0000", u_if.sent_cnt);
    else n_pass++;
    // Start a frame, then reset it asynchronously while in WAIT_LO.
    @(negedge clk);
    rst = 1'b1;
    u_if.enable = 1'b1;
    push_byte(8'h5A);
    wait_busy();
    repeat (2) @(negedge clk);
    n_total++;
    if (u_if.tx_data !== 8'h5A) $display("FAIL pre_reset_data: got %h, required 5a", u_if.tx_data);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_total++;
    if (u_if.tx_data !== 8'h00) $display("FAIL async_reset_data: got %h, required 00", u_if.tx_data);
    else n_pass++;
    n_total++;
    if (u_if.tx_valid !== 1'b0 || u_if.fifo_rinc !== 1'b0 || u_if.retry !== 1'b0 || u_if.sent_cnt !== 16'h0)
      $display("FAIL async_reset_outs: valid=%b rinc=%b retry=%b cnt=%h, required 0", u_if.tx_valid, u_if.fifo_rinc, u_if.retry, u_if.sent_cnt);
    else n_pass++;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    v0 = n_valid;
    repeat (20) @(posedge clk); #1;
    n_total++;
    if (n_valid !== v0) $display("FAIL empty_after_reset: launches=%0d, required 0", n_valid - v0);
    else n_pass++;
  endtask

  task automatic test_single();
    int v0, r0;
    v0 = n_valid; r0 = n_rinc;
    push_byte(8'hA5);
    wait_sent(16'd1);
    n_total++;
    if (u_if.sent_cnt !== 16'd1) $display("FAIL single_cnt: got %0d, required 1", u_if.sent_cnt);
    else n_pass++;
    n_total++;
    if (n_valid - v0 !== 1 || n_rinc - r0 !== 1)
      $display("FAIL single_strobes: valid=%0d rinc=%0d, required 1 and 1", n_valid - v0, n_rinc - r0);
    else n_pass++;
    n_total++;
    if (last_data !== 8'hA5) $display("FAIL single_data: got %h, required a5", last_data);
    else n_pass++;
  endtask

  task automatic test_burst();
    launch_q.delete(); fall_q.delete();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    wait_sent(16'd4);
    n_total++;
    if (u_if.sent_cnt !== 16'd4) $display("FAIL burst_cnt: got %0d, required 4", u_if.sent_cnt);
    else n_pass++;
    n_total++;
    if (launch_q.size() != 3 || fall_q.size() != 3) begin
      $display("FAIL burst_count: launches=%0d falls=%0d, required 3 and 3", launch_q.size(), fall_q.size());
    end else begin
      n_pass++;
      for (int i = 0; i < 2; i++) begin
        n_total++;
        if (launch_q[i+1] - fall_q[i] != 4)
          $display("FAIL burst_gap%0d: %0d cycles, required 4", i, launch_q[i+1] - fall_q[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_retry();
    int r0, q0;
    launch_q.delete();
    r0 = n_rinc; q0 = n_retry;
    tx_ignore = 1;
    push_byte(8'h3C);
    wait_sent(16'd5);
    n_total++;
    if (u_if.sent_cnt !== 16'd5) $display("FAIL retry_cnt: got %0d, required 5", u_if.sent_cnt);
    else n_pass++;
    n_total++;
    if (launch_q.size() != 2) $display("FAIL retry_launches: got %0d, required 2", launch_q.size());
    else if (launch_q[1] - launch_q[0] != 9)
      $display("FAIL retry_spacing: %0d cycles, required 9", launch_q[1] - launch_q[0]);
    else n_pass++;
    n_total++;
    if (n_rinc - r0 !== 1 || n_retry - q0 !== 1)
      $display("FAIL retry_strobes: rinc=%0d retry=%0d, required 1 and 1", n_rinc - r0, n_retry - q0);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    int v0, t;
    v0 = n_valid;
    push_byte(8'h77); push_byte(8'h88);
    wait_busy();
    repeat (2) @(negedge clk);
    u_if.enable = 1'b0;
    wait_sent(16'd6);
    n_total++;
    if (u_if.sent_cnt !== 16'd6) $display("FAIL drop_cnt: got %0d, required 6", u_if.sent_cnt);
    else n_pass++;
    repeat (20) @(posedge clk); #1;
    n_total++;
    if (n_valid - v0 !== 1) $display("FAIL drop_blocked: launches=%0d, required 1", n_valid - v0);
    else n_pass++;
    launch_q.delete();
    @(negedge clk);
    t = cyc;
    u_if.enable = 1'b1;
    wait_sent(16'd7);
    n_total++;
    if (u_if.sent_cnt !== 16'd7) $display("FAIL resume_cnt: got %0d, required 7", u_if.sent_cnt);
    else n_pass++;
    n_total++;
    if (launch_q.size() < 1) $display("FAIL resume_launch: got none, required one");
    else if (launch_q[0] !== t + 2)
      $display("FAIL resume_latency: launch at %0d, required %0d", launch_q[0], t + 2);
    else n_pass++;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force u_if.sent_cnt = 16'hFFFF;
    @(negedge clk);
    release u_if.sent_cnt;
    push_byte(8'hC3);
    wait_sent(16'h0000);
    n_total++;
    if (u_if.sent_cnt !== 16'h0000) $display("FAIL wrap_cnt: got %h, required 0000", u_if.sent_cnt);
    else n_pass++;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL leftover_bytes: %0d unlaunched, required 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_retry();
    test_enable_drop();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler between the TX FIFO read side and the UART transmitter, in the UART clock domain. It pops one byte at a time from a first-word-fall-through FIFO, presents it to the transmitter with a one-cycle valid pulse, and tracks the transmitter's busy level to detect acceptance and completion. It also enforces a programmable inter-frame gap, retries a launch that is not acknowledged, and counts completed frames.

## Interface
Parameters:
- W, 8: data width of FIFO word and TX byte.
- GAP, 2: idle clk cycles inserted after each completed frame (0 allowed).
- ACK_TO, 8: cycles to wait for tx_busy to rise after a launch before re-launching (≥1).

Ports:
- clk  input  1  UART-domain clock.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  scheduler may start new frames; sampled only in IDLE.
- fifo_empty  input  1  FIFO read-side empty flag (already in clk domain).
- fifo_rdata  input  W  FIFO head word; valid whenever fifo_empty=0.
- fifo_rinc  output  1  one-cycle pop strobe to FIFO.
- tx_busy  input  1  transmitter busy level (already in clk domain).
- tx_data  output  W  byte presented to transmitter; held stable between launches.
- tx_valid  output  1  one-cycle launch strobe to transmitter.
- sent_cnt  output  16  completed-frame counter, wraps.
- retry  output  1  one-cycle pulse on every re-launch after an ACK_TO expiry.

## Operation
- All outputs are registered. Reset (rst=0, asynchronous) drives state=IDLE, tx_data=0, tx_valid=0, fifo_rinc=0, sent_cnt=0, retry=0, and clears the gap and timeout counters.
- States: IDLE, LAUNCH, WAIT_HI, WAIT_LO, GAP.
- IDLE: if enable=1 and fifo_empty=0 and tx_busy=0, capture fifo_rdata into tx_data and go to LAUNCH. Otherwise stay in IDLE.
- LAUNCH (one cycle): tx_valid=1. fifo_rinc=1 only on the first launch of a byte; it is 0 on retries. Go to WAIT_HI with the timeout counter at 0.
- WAIT_HI:
  - If tx_busy=1, go to WAIT_LO.
  - Otherwise increment the timeout counter. When it reaches ACK_TO, pulse retry and go to LAUNCH with the same tx_data.
  - Retries are unlimited.
- WAIT_LO:
  - When tx_busy=0, increment sent_cnt (0xFFFF wraps to 0x0000).
  - Then go to GAP if GAP>0, else go directly to IDLE.
- GAP: count GAP cycles, then go to IDLE. fifo_empty and enable are ignored here.
- Deasserting enable mid-frame does not abort the frame; it only blocks the next IDLE start.
- fifo_empty changing while not in IDLE has no effect.
- A reset mid-frame loses any byte that has already been popped. This is accepted; the frame is not re-sent.
- tx_data changes only on the IDLE→LAUNCH capture and on reset.

## Timing
- Start latency: start condition true in IDLE at edge k → tx_valid=1, fifo_rinc=1, and the new tx_data are all visible during the cycle after edge k+1 (1 cycle).
- tx_valid and fifo_rinc are exactly 1 cycle wide and coincide on the first launch.
- Retry: if tx_busy stays 0 for ACK_TO cycles in WAIT_HI, tx_valid and retry both pulse again ACK_TO+1 cycles after the previous tx_valid. fifo_rinc stays 0.
- Frame completion: tx_busy sampled 0 in WAIT_LO at edge m → sent_cnt updates at edge m.
- Back-to-back frames: the next tx_valid is no earlier than GAP+2 cycles after the edge at which tx_busy fell (WAIT_LO exit, GAP cycles, IDLE check).
- GAP=0: IDLE is re-entered on the edge after completion. The next launch is then 1 further cycle later if the FIFO is non-empty.
- If tx_busy is already 1 in IDLE, no launch occurs; the scheduler waits for tx_busy=0.
- Simultaneous events: if tx_busy rises on the same edge the timeout expires, the busy rise wins and the FSM goes to WAIT_LO with no retry.

## Test plan
- Reset values: assert rst mid-WAIT_LO → all outputs 0 immediately without a clock edge. After release with FIFO empty, there is no tx_valid for 20 cycles.
- Single byte: FIFO holds 0xA5, enable=1, TX model raises busy 2 cycles after valid and holds it 10 cycles.
  - Required: one tx_valid with tx_data=0xA5 and one fifo_rinc.
  - Required: sent_cnt=1 after busy falls.
- Burst: 3 bytes (0x11, 0x22, 0x33), GAP=2.
  - Required: three launches in order, sent_cnt=3.
  - Required: each launch exactly 4 cycles after the prior busy fall (busy fall, 2-cycle gap, IDLE check).
- Retry: TX model ignores the first valid, then accepts the second, with ACK_TO=8.
  - Required: second tx_valid 9 cycles after the first, retry=1 with it, fifo_rinc pulsed only once, sent_cnt=1.
- Enable drop: deassert enable during WAIT_LO with 2 bytes queued.
  - Required: the current frame completes and the counter increments.
  - Required: no further launch until enable=1, then the next byte launches 1 cycle after enable is sampled in IDLE.
- Counter wrap: preload sent_cnt via 65536 short frames (or a forced value of 0xFFFF).
  - Required: the next completion yields 0x0000.
